// File: rtl/draw_pkg.sv
// Drawing constants shared by the full-screen drawers and the VGA chain.
package draw_pkg;
  localparam logic [11:0] BLACK = 12'h000;
endpackage

// File: rtl/game_pkg.sv
// Game-wide types shared between the game FSM and the screen path.
package game_pkg;
  typedef enum logic [1:0] {
    SCR_START   = 2'd0,
    SCR_KEEPER  = 2'd1,
    SCR_SHOOTER = 2'd2,
    SCR_END     = 2'd3
  } screen_t;
endpackage

// File: rtl/screen_switch_ctl_pkg.sv
// Local types for the screen sequencer: FSM states, registered VGA bundle, source mux.
package screen_switch_ctl_pkg;
  import game_pkg::*;
  import draw_pkg::*;

  typedef enum logic [1:0] {
    SHOW       = 2'd0,
    WAIT_FRAME = 2'd1,
    BLANK      = 2'd2
  } state_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  function automatic logic [11:0] pick_rgb(
    input screen_t     sel,
    input logic [11:0] rgb_start,
    input logic [11:0] rgb_keeper,
    input logic [11:0] rgb_shooter,
    input logic [11:0] rgb_end
  );
    logic [11:0] rgb;
    case (sel)
      SCR_START:   rgb = rgb_start;
      SCR_KEEPER:  rgb = rgb_keeper;
      SCR_SHOOTER: rgb = rgb_shooter;
      SCR_END:     rgb = rgb_end;
      default:     rgb = BLACK;
    endcase
    return rgb;
  endfunction
endpackage

// File: rtl/vga_if.sv
// VGA stream bundle: timing counters, sync/blank flags and 12-bit colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/screen_switch_ctl_frame_edge_det.sv
// Frame boundary detector: one-cycle fb pulse on the rising edge of vblnk.
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic fb
);
  logic vblnk_dly_d;
  logic vblnk_dly_q;

  always_comb begin
    vblnk_dly_d = vblnk;
  end

  always_ff @(posedge clk) begin
    if (rst) vblnk_dly_q <= 1'b0;
    else     vblnk_dly_q <= vblnk_dly_d;
  end

  assign fb = vblnk & ~vblnk_dly_q;
endmodule

// File: rtl/screen_switch_ctl.sv
// Frame-synchronous screen sequencer: forwards one drawer stream, switching only at
// frame boundaries with BLANK_FRAMES black frames in between. Output latency 1 clk.
module screen_switch_ctl
  import game_pkg::*;
  import draw_pkg::*;
  import screen_switch_ctl_pkg::*;
#(
  parameter int BLANK_FRAMES = 2
) (
  input  logic    clk,
  input  logic    rst,
  vga_if.in       in_start,
  vga_if.in       in_keeper,
  vga_if.in       in_shooter,
  vga_if.in       in_end,
  input  logic    req_valid,
  input  screen_t req_screen,
  output logic    req_ready,
  output screen_t cur_screen,
  output logic    busy,
  output logic    switch_done,
  vga_if.out      out
);
  localparam logic [3:0] CNT_INIT = 4'(BLANK_FRAMES);

  state_t  state_d, state_q;
  screen_t cur_d, cur_q;
  screen_t pend_d, pend_q;
  logic [3:0] cnt_d, cnt_q;
  logic    done_d, done_q;
  vga_t    out_d, out_q;
  logic    fb;

  frame_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .vblnk (in_start.vblnk),
    .fb    (fb)
  );

  assign req_ready = ~rst & (state_q == SHOW);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      SHOW: begin
        if (req_valid && req_ready && (req_screen != cur_q)) begin
          pend_d  = req_screen;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // A boundary seen in the accept cycle is not visible here; the switch waits one frame.
        if (fb) begin
          if (BLANK_FRAMES == 0) begin
            cur_d   = pend_q;
            done_d  = 1'b1;
            state_d = SHOW;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (fb) begin
          if (cnt_q == 4'd1) begin
            cur_d   = pend_q;
            done_d  = 1'b1;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = SHOW;
    endcase
  end

  always_comb begin
    out_d.hcount = in_start.hcount;
    out_d.vcount = in_start.vcount;
    out_d.hsync  = in_start.hsync;
    out_d.vsync  = in_start.vsync;
    out_d.hblnk  = in_start.hblnk;
    out_d.vblnk  = in_start.vblnk;
    out_d.rgb    = (state_q == BLANK) ? BLACK
                 : pick_rgb(cur_q, in_start.rgb, in_keeper.rgb, in_shooter.rgb, in_end.rgb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      cur_q   <= SCR_START;
      pend_q  <= SCR_START;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign cur_screen  = cur_q;
  assign busy        = (state_q != SHOW);
  assign switch_done = done_q;

  assign out.hcount = out_q.hcount;
  assign out.vcount = out_q.vcount;
  assign out.hsync  = out_q.hsync;
  assign out.vsync  = out_q.vsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.vblnk  = out_q.vblnk;
  assign out.rgb    = out_q.rgb;
endmodule

// File: tb/tb_screen_switch_ctl.sv
// Bench for screen_switch_ctl: two instances (BLANK_FRAMES 2 and 0) on a tiny raster.
module tb_screen_switch_ctl;
  import game_pkg::*;

  localparam int H_TOT = 16, H_VIS = 10, V_TOT = 8, V_VIS = 6;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    req_valid;
  screen_t req_screen;
  logic    rdy  [2];
  screen_t cur  [2];
  logic    bsy  [2];
  logic    done [2];

  vga_if s_start(), s_keeper(), s_shooter(), s_end(), o_bf2(), o_bf0();

  always #5 clk = ~clk;

  screen_switch_ctl #(.BLANK_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .in_start(s_start), .in_keeper(s_keeper),
    .in_shooter(s_shooter), .in_end(s_end), .req_valid(req_valid),
    .req_screen(req_screen), .req_ready(rdy[0]), .cur_screen(cur[0]),
    .busy(bsy[0]), .switch_done(done[0]), .out(o_bf2)
  );

  screen_switch_ctl #(.BLANK_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst), .in_start(s_start), .in_keeper(s_keeper),
    .in_shooter(s_shooter), .in_end(s_end), .req_valid(req_valid),
    .req_screen(req_screen), .req_ready(rdy[1]), .cur_screen(cur[1]),
    .busy(bsy[1]), .switch_done(done[1]), .out(o_bf0)
  );

  int n_vec = 0, n_err = 0;
  int hcnt = 0, vcnt = 0;
  int bf [2] = '{2, 0};

  // Reference: after acceptance, count boundaries; switch on boundary number bf+1.
  logic    m_busy [2];
  int      m_fbs  [2];
  screen_t m_cur  [2];
  screen_t m_pend [2];
  logic    m_done [2];
  logic    m_vd   [2];

  exp_t sb_q[$];
  int black_vis [2];
  int done_cnt  [2];
  int busy_cnt  [2];

  function automatic logic [11:0] src_rgb(int s, int h, int v);
    logic [3:0] sv, hv, vv;
    sv = 4'(s + 1);
    hv = 4'(h);
    vv = 4'(v);
    return {sv, vv, hv};
  endfunction

  function automatic exp_t obs(int i);
    exp_t e;
    if (i == 0) e = {o_bf2.hcount, o_bf2.vcount, o_bf2.hsync, o_bf2.vsync,
                     o_bf2.hblnk, o_bf2.vblnk, o_bf2.rgb};
    else        e = {o_bf0.hcount, o_bf0.vcount, o_bf0.hsync, o_bf0.vsync,
                     o_bf0.hblnk, o_bf0.vblnk, o_bf0.rgb};
    return e;
  endfunction

  task automatic model_step(int i);
    logic fb;
    m_done[i] = 1'b0;
    if (rst) begin
      m_busy[i] = 1'b0; m_fbs[i] = 0; m_cur[i] = SCR_START; m_vd[i] = 1'b0;
    end else begin
      fb = s_start.vblnk && !m_vd[i];
      if (m_busy[i] && fb) begin
        if (m_fbs[i] == bf[i]) begin
          m_cur[i] = m_pend[i]; m_busy[i] = 1'b0; m_done[i] = 1'b1; m_fbs[i] = 0;
        end else begin
          m_fbs[i] = m_fbs[i] + 1;
        end
      end else if (!m_busy[i] && req_valid && req_screen != m_cur[i]) begin
        m_pend[i] = req_screen; m_busy[i] = 1'b1; m_fbs[i] = 0;
      end
      m_vd[i] = s_start.vblnk;
    end
  endtask

  task automatic run_cycle();
    exp_t e, o;
    s_start.hcount = 11'(hcnt);   s_start.vcount = 11'(vcnt);
    s_start.hblnk  = (hcnt >= H_VIS); s_start.vblnk = (vcnt >= V_VIS);
    s_start.hsync  = (hcnt == 11 || hcnt == 12); s_start.vsync = (vcnt == 7);
    s_keeper.hcount = s_start.hcount; s_shooter.hcount = s_start.hcount; s_end.hcount = s_start.hcount;
    s_keeper.vcount = s_start.vcount; s_shooter.vcount = s_start.vcount; s_end.vcount = s_start.vcount;
    s_keeper.hblnk = s_start.hblnk; s_shooter.hblnk = s_start.hblnk; s_end.hblnk = s_start.hblnk;
    s_keeper.vblnk = s_start.vblnk; s_shooter.vblnk = s_start.vblnk; s_end.vblnk = s_start.vblnk;
    s_keeper.hsync = s_start.hsync; s_shooter.hsync = s_start.hsync; s_end.hsync = s_start.hsync;
    s_keeper.vsync = s_start.vsync; s_shooter.vsync = s_start.vsync; s_end.vsync = s_start.vsync;
    s_start.rgb   = src_rgb(0, hcnt, vcnt);
    s_keeper.rgb  = src_rgb(1, hcnt, vcnt);
    s_shooter.rgb = src_rgb(2, hcnt, vcnt);
    s_end.rgb     = src_rgb(3, hcnt, vcnt);
    for (int i = 0; i < 2; i++) begin
      if (rst) e = '0;
      else begin
        e = {s_start.hcount, s_start.vcount, s_start.hsync, s_start.vsync,
             s_start.hblnk, s_start.vblnk, 12'h000};
        e.rgb = (m_busy[i] && m_fbs[i] >= 1) ? 12'h000 : src_rgb(int'(m_cur[i]), hcnt, vcnt);
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      e = sb_q.pop_front();
      o = obs(i);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL out_bundle[%0d] t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                 i, $time, o.hc, o.vc, o.hs, o.vs, o.hb, o.vb, o.rgb,
                 e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, e.rgb);
      end
      n_vec++;
      if (cur[i] !== m_cur[i] || bsy[i] !== m_busy[i] || done[i] !== m_done[i] ||
          rdy[i] !== (!rst && !m_busy[i])) begin
        n_err++;
        $display("FAIL status[%0d] t=%0t got cur=%0d busy=%b done=%b rdy=%b want cur=%0d busy=%b done=%b rdy=%b",
                 i, $time, cur[i], bsy[i], done[i], rdy[i],
                 m_cur[i], m_busy[i], m_done[i], !rst && !m_busy[i]);
      end
      if (!o.hb && !o.vb && o.rgb == 12'h000 && !rst) black_vis[i]++;
      if (done[i] === 1'b1) done_cnt[i]++;
      if (bsy[i] === 1'b1) busy_cnt[i]++;
    end
    hcnt++;
    if (hcnt == H_TOT) begin
      hcnt = 0;
      vcnt = (vcnt + 1) % V_TOT;
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      black_vis[i] = 0; done_cnt[i] = 0; busy_cnt[i] = 0;
    end
  endtask

  task automatic run_frames(int n);
    for (int k = 0; k < n * H_TOT * V_TOT; k++) run_cycle();
  endtask

  task automatic wait_line(int v);
    int guard = 0;
    while (!(vcnt == v && hcnt == 3) && guard < 2 * H_TOT * V_TOT) begin
      run_cycle();
      guard++;
    end
    n_vec++;
    if (!(vcnt == v && hcnt == 3)) begin
      n_err++;
      $display("FAIL wait_line got v=%0d h=%0d want v=%0d h=3", vcnt, hcnt, v);
    end
  endtask

  task automatic request(screen_t s);
    req_valid = 1'b1; req_screen = s;
    run_cycle();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_screen = SCR_START;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_fbs[i] = 0; m_cur[i] = SCR_START; m_pend[i] = SCR_START;
      m_done[i] = 1'b0; m_vd[i] = 1'b0;
    end
    repeat (3) run_cycle();
    rst = 1'b0;
    run_cycle();
    n_vec++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready got %b%b want 11", rdy[0], rdy[1]);
    end
  endtask

  task automatic test_idle();
    clear_stats();
    run_frames(2);
    n_vec++;
    if (done_cnt[0] + done_cnt[1] + busy_cnt[0] + busy_cnt[1] != 0 || cur[0] !== SCR_START) begin
      n_err++;
      $display("FAIL idle got done=%0d busy=%0d cur=%0d want 0 0 0",
               done_cnt[0] + done_cnt[1], busy_cnt[0] + busy_cnt[1], cur[0]);
    end
  endtask

  task automatic test_switch_keeper();
    wait_line(3);
    clear_stats();
    request(SCR_KEEPER);
    run_frames(4);
    n_vec++;
    if (black_vis[0] != 2 * H_VIS * V_VIS || black_vis[1] != 0) begin
      n_err++;
      $display("FAIL keeper_black_pixels got %0d/%0d want %0d/0",
               black_vis[0], black_vis[1], 2 * H_VIS * V_VIS);
    end
    n_vec++;
    if (done_cnt[0] != 1 || done_cnt[1] != 1 || cur[0] !== SCR_KEEPER) begin
      n_err++;
      $display("FAIL keeper_done got %0d/%0d cur=%0d want 1/1 cur=1", done_cnt[0], done_cnt[1], cur[0]);
    end
  endtask

  task automatic test_switch_end();
    wait_line(2);
    clear_stats();
    request(SCR_END);
    run_frames(4);
    n_vec++;
    if (black_vis[1] != 0 || cur[1] !== SCR_END || cur[0] !== SCR_END || done_cnt[1] != 1) begin
      n_err++;
      $display("FAIL end_switch got black=%0d cur=%0d/%0d done=%0d want 0 3/3 1",
               black_vis[1], cur[0], cur[1], done_cnt[1]);
    end
  endtask

  task automatic test_same_screen();
    wait_line(1);
    clear_stats();
    request(SCR_END);
    run_frames(2);
    n_vec++;
    if (busy_cnt[0] + busy_cnt[1] + done_cnt[0] + done_cnt[1] + black_vis[0] + black_vis[1] != 0) begin
      n_err++;
      $display("FAIL same_screen got busy=%0d done=%0d black=%0d want 0 0 0",
               busy_cnt[0] + busy_cnt[1], done_cnt[0] + done_cnt[1], black_vis[0] + black_vis[1]);
    end
  endtask

  task automatic test_ignore_in_blank();
    wait_line(3);
    clear_stats();
    request(SCR_SHOOTER);
    wait_line(7);
    req_valid = 1'b1; req_screen = SCR_END;
    for (int k = 0; k < 20; k++) begin
      run_cycle();
      n_vec++;
      if (rdy[0] !== 1'b0) begin
        n_err++;
        $display("FAIL ignore_ready got %b want 0", rdy[0]);
      end
    end
    req_valid = 1'b0;
    run_frames(4);
    n_vec++;
    if (cur[0] !== SCR_SHOOTER || done_cnt[0] != 1) begin
      n_err++;
      $display("FAIL ignore_final got cur=%0d done=%0d want cur=2 done=1", cur[0], done_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_blank();
    wait_line(3);
    request(SCR_KEEPER);
    wait_line(7);
    rst = 1'b1;
    run_cycle();
    n_vec++;
    if (cur[0] !== SCR_START || bsy[0] !== 1'b0 || obs(0) !== '0) begin
      n_err++;
      $display("FAIL reset_mid_blank got cur=%0d busy=%b out=%h want 0 0 0", cur[0], bsy[0], obs(0));
    end
    rst = 1'b0;
    clear_stats();
    run_frames(4);
    n_vec++;
    if (done_cnt[0] != 0 || busy_cnt[0] != 0 || cur[0] !== SCR_START || black_vis[0] != 0) begin
      n_err++;
      $display("FAIL reset_no_stale got done=%0d busy=%0d cur=%0d black=%0d want 0 0 0 0",
               done_cnt[0], busy_cnt[0], cur[0], black_vis[0]);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_switch_keeper();
    test_switch_end();
    test_same_screen();
    test_ignore_in_blank();
    test_reset_mid_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
